// File: rtl/break_vector_builder_if.sv
// Occurrence stream and break-vector result bundle between the WalkSAT clause
// walker, the break_vector_builder and the downstream break-value counter.
interface break_vector_builder_if #(
  parameter int MAX_OCC = 20,
  parameter int NT_W    = 4,
  parameter int VAR_W   = 10
);
  logic               occ_valid;
  logic               occ_ready;
  logic [NT_W-1:0]    occ_numtrue;
  logic               occ_lit_true;
  logic               occ_last;
  logic [MAX_OCC-1:0] brk;
  logic [VAR_W-1:0]   brk_var;
  logic [4:0]         occ_count;
  logic               overflow;
  logic               brk_valid;
  logic               brk_ready;

  modport master (
    output occ_valid, occ_numtrue, occ_lit_true, occ_last, brk_ready,
    input  occ_ready, brk, brk_var, occ_count, overflow, brk_valid
  );

  modport slave (
    input  occ_valid, occ_numtrue, occ_lit_true, occ_last, brk_ready,
    output occ_ready, brk, brk_var, occ_count, overflow, brk_valid
  );
endinterface

// File: rtl/break_vector_builder.sv
// Collects one variable's clause occurrences into a break vector (bit i set when
// flipping the variable would unsatisfy occurrence i) and hands it downstream.
module break_vector_builder #(
  parameter int MAX_OCC = 20,
  parameter int NT_W    = 4,
  parameter int VAR_W   = 10
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [VAR_W-1:0] start_var,
  output logic             busy,
  break_vector_builder_if.slave bus
);

  typedef enum logic [1:0] {IDLE, COLLECT, DONE} state_t;

  localparam logic [4:0]         MAX_CNT = 5'(MAX_OCC);
  localparam logic [MAX_OCC-1:0] ONE_HOT = MAX_OCC'(1);

  state_t             r_state;
  state_t             w_next;
  logic [MAX_OCC-1:0] r_brk;
  logic [VAR_W-1:0]   r_brk_var;
  logic [4:0]         r_occ_count;
  logic               r_overflow;
  logic               w_occ_ready;
  logic               w_brk_valid;
  logic               w_busy;
  logic               w_accept;
  logic               w_break;

  // A clause breaks only if our literal is its sole true literal; numtrue==0 is inconsistent and ignored.
  assign w_accept = bus.occ_valid & w_occ_ready;
  assign w_break  = bus.occ_lit_true & (bus.occ_numtrue == NT_W'(1));

  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (start)                   w_next = COLLECT;
      COLLECT: if (w_accept && bus.occ_last) w_next = DONE;
      DONE:    if (bus.brk_ready)            w_next = IDLE;
      default:                              w_next = IDLE;
    endcase
  end

  always_comb begin
    w_occ_ready = (r_state == COLLECT);
    w_brk_valid = (r_state == DONE);
    w_busy      = (r_state != IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_brk       <= '0;
      r_brk_var   <= '0;
      r_occ_count <= '0;
      r_overflow  <= 1'b0;
    end else if (r_state == IDLE && start) begin
      r_brk       <= '0;
      r_brk_var   <= start_var;
      r_occ_count <= '0;
      r_overflow  <= 1'b0;
    end else if (w_accept) begin
      // Beats beyond the vector width only flag overflow; the count stays saturated.
      if (r_occ_count < MAX_CNT) begin
        if (w_break) r_brk <= r_brk | (ONE_HOT << r_occ_count);
        r_occ_count <= r_occ_count + 5'd1;
      end else begin
        r_overflow <= 1'b1;
      end
    end
  end

  assign bus.occ_ready = w_occ_ready;
  assign bus.brk_valid = w_brk_valid;
  assign bus.brk       = r_brk;
  assign bus.brk_var   = r_brk_var;
  assign bus.occ_count = r_occ_count;
  assign bus.overflow  = r_overflow;
  assign busy          = w_busy;

endmodule

// File: tb/tb_break_vector_builder.sv
// Directed self-checking bench for break_vector_builder: hand-computed break
// vectors, saturation/overflow, DONE backpressure, mid-stream reset and gaps.
module tb_break_vector_builder;

  localparam int MAX_OCC = 20;
  localparam int NT_W    = 4;
  localparam int VAR_W   = 10;

  logic             clk = 1'b0;
  logic             rst;
  logic             start;
  logic [VAR_W-1:0] start_var;
  logic             busy;

  int checkCount = 0;
  int errorCount = 0;

  break_vector_builder_if #(.MAX_OCC(MAX_OCC), .NT_W(NT_W), .VAR_W(VAR_W)) bif ();

  break_vector_builder #(.MAX_OCC(MAX_OCC), .NT_W(NT_W), .VAR_W(VAR_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .start_var (start_var),
    .busy      (busy),
    .bus       (bif)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checkCount++;
    if (observed !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  task automatic waitCycle();
    @(posedge clk);
    #1;
  endtask

  task automatic startVar(input logic [VAR_W-1:0] v);
    start     = 1'b1;
    start_var = v;
    waitCycle();
    start     = 1'b0;
  endtask

  // Present one beat and hold it until it is taken at a clock edge.
  task automatic applyStimulus(input logic [NT_W-1:0] nt, input logic lt, input logic last);
    int n;
    bif.occ_valid    = 1'b1;
    bif.occ_numtrue  = nt;
    bif.occ_lit_true = lt;
    bif.occ_last     = last;
    n = 0;
    while (!bif.occ_ready && n < 50) begin
      waitCycle();
      n++;
    end
    if (!bif.occ_ready) checkOutput("occ_ready_timeout", 32'(bif.occ_ready), 32'd1);
    waitCycle();
    bif.occ_valid = 1'b0;
    bif.occ_last  = 1'b0;
  endtask

  task automatic checkResult(input string tag, input logic [MAX_OCC-1:0] b, input logic [4:0] cnt,
                             input logic ovf, input logic [VAR_W-1:0] v);
    checkOutput({tag, "_valid"}, 32'(bif.brk_valid), 32'd1);
    checkOutput({tag, "_brk"},   32'(bif.brk),       32'(b));
    checkOutput({tag, "_count"}, 32'(bif.occ_count), 32'(cnt));
    checkOutput({tag, "_ovf"},   32'(bif.overflow),  32'(ovf));
    checkOutput({tag, "_var"},   32'(bif.brk_var),   32'(v));
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst = 1'b1; start = 1'b0; start_var = '0;
    bif.occ_valid = 1'b0; bif.occ_numtrue = '0; bif.occ_lit_true = 1'b0;
    bif.occ_last = 1'b0; bif.brk_ready = 1'b0;
    waitCycle();
    waitCycle();
    rst = 1'b0;
    checkOutput("rst_brk",   32'(bif.brk),       32'd0);
    checkOutput("rst_valid", 32'(bif.brk_valid), 32'd0);
    checkOutput("rst_ready", 32'(bif.occ_ready), 32'd0);
    checkOutput("rst_busy",  32'(busy),          32'd0);
    checkOutput("rst_count", 32'(bif.occ_count), 32'd0);

    // Basic three-beat stream.
    startVar(10'd7);
    checkOutput("t1_ready_latency", 32'(bif.occ_ready), 32'd1);
    applyStimulus(4'd1, 1'b1, 1'b0);
    applyStimulus(4'd2, 1'b1, 1'b0);
    checkOutput("t1_valid_early", 32'(bif.brk_valid), 32'd0);
    applyStimulus(4'd1, 1'b0, 1'b1);
    checkResult("t1", 20'h00001, 5'd3, 1'b0, 10'd7);
    checkOutput("t1_ready_done", 32'(bif.occ_ready), 32'd0);
    bif.brk_ready = 1'b1;
    waitCycle();
    bif.brk_ready = 1'b0;
    checkOutput("t1_valid_drop", 32'(bif.brk_valid), 32'd0);
    checkOutput("t1_idle",       32'(busy),          32'd0);
    checkOutput("t1_hold_brk",   32'(bif.brk),       32'h00001);

    // Full vector with consumer always ready.
    bif.brk_ready = 1'b1;
    startVar(10'd300);
    for (int i = 0; i < 20; i++) applyStimulus(4'd1, 1'b1, i == 19);
    checkResult("t2", 20'hFFFFF, 5'd20, 1'b0, 10'd300);
    waitCycle();
    checkOutput("t2_valid_one_cycle", 32'(bif.brk_valid), 32'd0);
    checkOutput("t2_idle",            32'(busy),          32'd0);
    bif.brk_ready = 1'b0;

    // Overflow: 22 beats, only odd-indexed beats break.
    startVar(10'd513);
    for (int i = 0; i < 22; i++) begin
      if (i % 2 == 1) applyStimulus(4'd1, 1'b1, i == 21);
      else            applyStimulus(4'd3, 1'b1, i == 21);
    end
    checkResult("t3", 20'hAAAAA, 5'd20, 1'b1, 10'd513);

    // Backpressure in DONE with noise on start and occ_valid.
    for (int i = 0; i < 5; i++) begin
      start = ~start; start_var = 10'd99;
      bif.occ_valid = ~bif.occ_valid;
      bif.occ_numtrue = 4'd1; bif.occ_lit_true = 1'b1;
      waitCycle();
      checkResult("t4_hold", 20'hAAAAA, 5'd20, 1'b1, 10'd513);
      checkOutput("t4_ready", 32'(bif.occ_ready), 32'd0);
    end
    start = 1'b0; bif.occ_valid = 1'b0;
    bif.brk_ready = 1'b1;
    waitCycle();
    bif.brk_ready = 1'b0;
    checkOutput("t4_release_valid", 32'(bif.brk_valid), 32'd0);
    checkOutput("t4_release_idle",  32'(busy),          32'd0);
    checkOutput("t4_release_var",   32'(bif.brk_var),   32'd513);

    // Reset in the middle of a stream.
    startVar(10'd5);
    applyStimulus(4'd1, 1'b1, 1'b0);
    applyStimulus(4'd1, 1'b1, 1'b0);
    rst = 1'b1;
    waitCycle();
    rst = 1'b0;
    checkOutput("t5_brk",   32'(bif.brk),       32'd0);
    checkOutput("t5_var",   32'(bif.brk_var),   32'd0);
    checkOutput("t5_count", 32'(bif.occ_count), 32'd0);
    checkOutput("t5_ovf",   32'(bif.overflow),  32'd0);
    checkOutput("t5_ready", 32'(bif.occ_ready), 32'd0);
    checkOutput("t5_busy",  32'(busy),          32'd0);
    startVar(10'd9);
    applyStimulus(4'd1, 1'b1, 1'b1);
    checkResult("t5_after", 20'h00001, 5'd1, 1'b0, 10'd9);
    bif.brk_ready = 1'b1;
    waitCycle();
    bif.brk_ready = 1'b0;

    // Gapped stream; idle cycles must not move the count.
    startVar(10'd3);
    for (int i = 0; i < 4; i++) begin
      bif.occ_valid = 1'b0;
      waitCycle();
      checkOutput("t6_gap_count", 32'(bif.occ_count), 32'(i));
      checkOutput("t6_gap_busy",  32'(bif.occ_ready), 32'd1);
      case (i)
        0: applyStimulus(4'd1, 1'b1, 1'b0);
        1: applyStimulus(4'd0, 1'b1, 1'b0);
        2: applyStimulus(4'd1, 1'b1, 1'b0);
        default: applyStimulus(4'd2, 1'b0, 1'b1);
      endcase
    end
    checkResult("t6", 20'h00005, 5'd4, 1'b0, 10'd3);

    $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
    $finish;
  end

endmodule

// File: doc/break_vector_builder.md
Name: break_vector_builder

Overview:
Producer side of the WalkSAT break-count path. For one candidate flip variable, it accepts a stream of that variable's clause occurrences. Each occurrence carries the clause's current true-literal count and whether the variable's literal in that clause is currently true. The block assembles the per-occurrence break vector (bit i = flipping the variable would unsatisfy occurrence i) and hands it, with a valid/ready handshake, to the downstream break-value counter.

Parameters:
MAX_OCC, 20, number of break-vector bits and maximum occurrences per variable
NT_W, 4, width of the clause true-literal count
VAR_W, 10, width of the variable index

Ports:
clk  input  1  clock, all logic on rising edge
rst  input  1  synchronous, active-high reset
start  input  1  pulse: begin collection for start_var; honoured only in IDLE
start_var  input  VAR_W  variable index, latched on accepted start
occ_valid  input  1  occurrence beat valid
occ_ready  output  1  block accepts occurrence beat
occ_numtrue  input  NT_W  current number of true literals in the clause
occ_lit_true  input  1  variable's literal in this clause is currently true
occ_last  input  1  final occurrence for this variable
brk  output  MAX_OCC  assembled break vector, bit 0 = first occurrence
brk_var  output  VAR_W  variable the vector belongs to
occ_count  output  5  occurrences accepted, saturates at MAX_OCC
overflow  output  1  more than MAX_OCC occurrences were presented
brk_valid  output  1  result valid
brk_ready  input  1  downstream consumes result
busy  output  1  state != IDLE

Behaviour:
- Reset (rst=1 at a clock edge): state=IDLE. brk=0, brk_var=0, occ_count=0, overflow=0, brk_valid=0, occ_ready=0, busy=0. Reset overrides every other input in the same cycle, including a reset that arrives mid-COLLECT or mid-DONE. Any partial vector is discarded.
- States: IDLE, COLLECT, DONE.
- IDLE: occ_ready=0. On start=1 the block latches start_var into brk_var, clears brk, occ_count and overflow, and moves to COLLECT on the next cycle.
- COLLECT: occ_ready=1. A beat is accepted when occ_valid and occ_ready are both 1. For accepted beat k (k = occ_count before the beat):
  - Break condition: occ_lit_true=1 AND occ_numtrue==1.
  - If k<MAX_OCC, brk[k] is set to the break condition.
  - If k>=MAX_OCC, overflow is set to 1 and brk is unchanged.
  - occ_count increments, saturating at MAX_OCC.
- occ_numtrue==0 with occ_lit_true=1 is inconsistent; it is treated as no-break (bit=0).
- An accepted beat with occ_last=1 moves the block to DONE on the next cycle. The last beat's bit is included.
- A variable with zero occurrences is not supported: the stream always carries at least one beat.
- DONE: brk_valid=1, occ_ready=0. brk, brk_var, occ_count and overflow are held stable. On brk_valid&&brk_ready the block returns to IDLE next cycle, brk_valid drops to 0, and outputs hold their values until the next start.
- Latency: start to first occ_ready = 1 cycle. Last accepted beat to brk_valid = 1 cycle. Handshake to IDLE = 1 cycle. Minimum per-variable time = N+2 cycles for N occurrences with no backpressure.
- start asserted outside IDLE is ignored, with no effect on any state.
- occ_valid outside COLLECT is ignored. The producer must hold the beat, since occ_ready=0.
- brk_ready while brk_valid=0 has no effect.

Test Plan:
- Reset then start_var=7 with 3 beats (numtrue,lit_true) = (1,1),(2,1),(1,0), last on beat 3 -> brk=20'h00001, occ_count=3, overflow=0, brk_var=7. brk_valid rises 1 cycle after beat 3.
- 20 beats all (1,1), last on beat 20, brk_ready=1 -> brk=20'hFFFFF, occ_count=20, overflow=0. brk_valid is high exactly 1 cycle, then busy=0.
- 22 beats with even beats (1,1) and odd beats (3,1) -> brk=20'hAAAAA, occ_count=20, overflow=1.
- Hold brk_ready=0 for 5 cycles in DONE, toggling start and occ_valid -> brk_valid stays 1, outputs constant, occ_ready=0. The first brk_ready=1 returns the block to IDLE next cycle.
- Assert rst after beat 2 of a 5-beat stream -> next cycle all outputs are 0 and state is IDLE. A new start with 1 beat (1,1) gives brk=20'h00001, occ_count=1.
- occ_valid toggled every other cycle (gaps) across 4 beats, pattern (1,1),(0,1),(1,1),(2,0) -> brk=20'h00005. Gap cycles leave state and count unchanged.
